// File: rtl/pipelined_datapath_if.sv
// Op, external-write and result bundle between the decoder side and the datapath.
interface pipelined_datapath_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8
);
  localparam int unsigned AW = $clog2(NREGS);

  logic             in_valid;
  logic [AW-1:0]    rs_a;
  logic [AW-1:0]    rs_b;
  logic [WIDTH-1:0] imm;
  logic             mux_sel;
  logic [2:0]       alu_sel;
  logic [AW-1:0]    rd;
  logic             wb_en;
  logic             ext_we;
  logic [AW-1:0]    ext_addr;
  logic [WIDTH-1:0] ext_data;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output in_valid, rs_a, rs_b, imm, mux_sel, alu_sel, rd, wb_en,
    output ext_we, ext_addr, ext_data,
    input  out_valid, result, carry_out, zero
  );

  modport slave (
    input  in_valid, rs_a, rs_b, imm, mux_sel, alu_sel, rd, wb_en,
    input  ext_we, ext_addr, ext_data,
    output out_valid, result, carry_out, zero
  );
endinterface

// File: rtl/pipelined_datapath.sv
// Two-stage register-file + ALU datapath with S1->S0 forwarding and an external preload port.
module pipelined_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREGS = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_datapath_if.slave bus
);
  localparam int unsigned AW = $clog2(NREGS);

  typedef struct packed {
    logic             valid;
    logic [2:0]       alu_sel;
    logic [AW-1:0]    rd;
    logic             wb_en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  s1_t              s1_q, s1_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             fwd_a, fwd_b;
  logic [WIDTH-1:0] op_a, op_b;

  // S1 ALU on the captured operands
  always_comb begin
    sum       = {1'b0, s1_q.a} + {1'b0, s1_q.b};
    alu_res   = '0;
    alu_carry = 1'b0;
    case (s1_q.alu_sel)
      3'b000: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      3'b001: begin
        alu_res   = s1_q.a - s1_q.b;
        alu_carry = (s1_q.a < s1_q.b);
      end
      3'b010: alu_res = s1_q.a & s1_q.b;
      3'b011: alu_res = s1_q.a | s1_q.b;
      3'b100: alu_res = s1_q.a ^ s1_q.b;
      3'b101: begin
        alu_res   = {s1_q.a[WIDTH-2:0], 1'b0};
        alu_carry = s1_q.a[WIDTH-1];
      end
      3'b110: begin
        alu_res   = {1'b0, s1_q.a[WIDTH-1:1]};
        alu_carry = s1_q.a[0];
      end
      default: alu_res = s1_q.b;
    endcase
  end

  // S0 operand fetch; the op retiring this cycle overrides the stale reg-file value
  always_comb begin
    fwd_a = s1_q.valid && s1_q.wb_en && (s1_q.rd == bus.rs_a);
    fwd_b = s1_q.valid && s1_q.wb_en && !bus.mux_sel && (s1_q.rd == bus.rs_b);
    op_a  = fwd_a ? alu_res : regs_q[bus.rs_a];
    if (bus.mux_sel)  op_b = bus.imm;
    else if (fwd_b)   op_b = alu_res;
    else              op_b = regs_q[bus.rs_b];
  end

  // Next-state: S1 capture, retirement outputs, reg-file writes (writeback after ext so it wins)
  always_comb begin
    s1_d        = s1_q;
    s1_d.valid  = bus.in_valid;
    if (bus.in_valid) begin
      s1_d.alu_sel = bus.alu_sel;
      s1_d.rd      = bus.rd;
      s1_d.wb_en   = bus.wb_en;
      s1_d.a       = op_a;
      s1_d.b       = op_b;
    end

    out_valid_d = s1_q.valid;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    if (s1_q.valid) begin
      result_d = alu_res;
      carry_d  = alu_carry;
      zero_d   = (alu_res == '0);
    end

    regs_d = regs_q;
    if (bus.ext_we)              regs_d[bus.ext_addr] = bus.ext_data;
    if (s1_q.valid && s1_q.wb_en) regs_d[s1_q.rd]     = alu_res;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      regs_q      <= regs_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;
endmodule
